// File: rtl/uart_autobaud.sv
// uart_autobaud: recovers the UART bit period from a 0x55 calibration
// character and produces the half-bit toggle divisor (CLK/BAUD/2 - 1).
//
// Handshake: this block has no valid/ready flow. `done` and `err` are
// single-cycle pulses. `bauddiv` is meaningful to the divider only while
// `locked` is high. A one-cycle `start` pulse is accepted in any state and
// has priority over every in-state event in the same cycle.
module uart_autobaud #(
  parameter int CNTW    = 21,
  parameter int MINBIT  = 16,
  parameter int IDLEMIN = 64,
  parameter int DEFDIV  = 2603
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            rx,
  input  logic            start,
  output logic [CNTW-5:0] bauddiv,
  output logic            locked,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [1:0]      dbg_state
);

  // FSM encoding
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;
  localparam logic [1:0] LOCKED  = 2'd3;

  localparam int IW = $clog2(IDLEMIN + 1);
  localparam logic [IW-1:0]   IDLE_TGT = IW'(IDLEMIN);
  // seg_cnt holds (cycles since last edge - 1), so an interval of exactly
  // MINBIT cycles shows up as MINBIT-1 and is still legal.
  localparam logic [CNTW-1:0] SEG_LIM  = CNTW'(MINBIT - 1);
  localparam logic [CNTW-1:0] TOT_MAX  = '1;
  localparam logic [CNTW-5:0] DEF_DIV  = (CNTW-4)'(DEFDIV);

  logic [1:0]      state;
  logic [1:0]      state_nxt;

  logic            rx_m;
  logic            rx_s;
  logic            rx_q;
  logic            fall;
  logic            rise;
  logic            edge_any;

  logic [IW-1:0]   idle_cnt;
  logic [IW-1:0]   idle_inc;
  logic [CNTW-1:0] tot_cnt;
  logic [CNTW-1:0] seg_cnt;
  logic [2:0]      fall_cnt;

  logic            idle_hit;
  logic            arm_go;
  logic            timeout;
  logic            glitch;
  logic            finish;

  logic [CNTW-1:0] t_total;
  logic [CNTW-5:0] new_div;

  // Two-flop synchronizer plus one delay flop for edge detection
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_q <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_q <= rx_s;
    end
  end

  assign fall     = rx_q & ~rx_s;
  assign rise     = ~rx_q & rx_s;
  assign edge_any = fall | rise;

  // tot_cnt is (cycles since the first falling edge - 1) at each detection,
  // so the full 8-bit-period span is tot_cnt + 1.
  assign t_total  = tot_cnt + CNTW'(1);
  assign new_div  = t_total[CNTW-1:4] - (CNTW-4)'(1);
  assign idle_inc = idle_cnt + IW'(1);

  // Decode the in-state events that drive the FSM and the datapath
  always_comb begin
    idle_hit = 1'b0;
    arm_go   = 1'b0;
    timeout  = 1'b0;
    glitch   = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE:    idle_hit = rx_s && (idle_inc == IDLE_TGT);
      ARMED:   arm_go   = fall;
      MEASURE: begin
        timeout = (tot_cnt == TOT_MAX);
        glitch  = !timeout && edge_any && (seg_cnt < SEG_LIM);
        finish  = !timeout && !glitch && fall && (fall_cnt == 3'd4);
      end
      default: ;
    endcase
  end

  // Next-state logic; start overrides everything
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (idle_hit) state_nxt = ARMED;
        ARMED:   if (arm_go) state_nxt = MEASURE;
        MEASURE: begin
          if (timeout || glitch) state_nxt = IDLE;
          else if (finish)       state_nxt = LOCKED;
        end
        LOCKED:  state_nxt = LOCKED;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Idle-high qualification counter; any low cycle restarts it
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      idle_cnt <= '0;
    end else if (start || (state != IDLE) || !rx_s || idle_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_inc;
    end
  end

  // Total span and per-edge segment counters
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tot_cnt <= '0;
      seg_cnt <= '0;
    end else if (start || arm_go) begin
      tot_cnt <= '0;
      seg_cnt <= '0;
    end else if (state == MEASURE) begin
      tot_cnt <= tot_cnt + CNTW'(1);
      seg_cnt <= edge_any ? '0 : (seg_cnt + CNTW'(1));
    end
  end

  // Falling-edge count; the arming edge is number 1
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fall_cnt <= 3'd0;
    end else if (start) begin
      fall_cnt <= 3'd0;
    end else if (arm_go) begin
      fall_cnt <= 3'd1;
    end else if ((state == MEASURE) && fall && !timeout && !glitch) begin
      fall_cnt <= fall_cnt + 3'd1;
    end
  end

  // Result register: only a completed measurement changes bauddiv
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bauddiv <= DEF_DIV;
    end else if (!start && finish) begin
      bauddiv <= new_div;
    end
  end

  // Lock flag: set on success, cleared by start
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      locked <= 1'b0;
    end else if (start) begin
      locked <= 1'b0;
    end else if (finish) begin
      locked <= 1'b1;
    end
  end

  // Single-cycle status pulses
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= !start && finish;
      err  <= !start && (timeout || glitch);
    end
  end

  assign busy      = (state != LOCKED);
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: table of calibration runs plus
// hand-written glitch, ignored-byte, reset and timeout sequences.
module tb_uart_autobaud;

  localparam int DEFDIV  = 2603;
  localparam int DEFDIV2 = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  logic        rx, start;
  logic [16:0] bauddiv;
  logic        locked, busy, done, err;
  logic [1:0]  dbg_state;

  logic        rx2, start2;
  logic [7:0]  bauddiv2;
  logic        locked2, busy2, done2, err2;
  logic [1:0]  dbg_state2;

  uart_autobaud u_dut (
    .clk(clk), .nrst(nrst), .rx(rx), .start(start),
    .bauddiv(bauddiv), .locked(locked), .busy(busy),
    .done(done), .err(err), .dbg_state(dbg_state)
  );

  // Narrow counter instance so the timeout is reachable in a short run
  uart_autobaud #(.CNTW(12), .MINBIT(16), .IDLEMIN(64), .DEFDIV(DEFDIV2)) u_to (
    .clk(clk), .nrst(nrst), .rx(rx2), .start(start2),
    .bauddiv(bauddiv2), .locked(locked2), .busy(busy2),
    .done(done2), .err(err2), .dbg_state(dbg_state2)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err)  err_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
  endtask

  // ---------------- drivers (all keep time at posedge+1) ----------------
  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  task automatic send_byte(input logic [7:0] b, input int n);
    drive_bit(1'b0, n);
    for (int i = 0; i < 8; i++) drive_bit(b[i], n);
    drive_bit(1'b1, n);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit do_start;
    int bitlen;
    int exp_div;
    bit junk_after;
  } cal_vec_t;

  cal_vec_t vecs[3];
  int prev_div;
  int lat;
  bit seen;

  initial begin
    vecs[0] = '{do_start: 1'b0, bitlen: 128,  exp_div: 63,   junk_after: 1'b1};
    vecs[1] = '{do_start: 1'b1, bitlen: 5208, exp_div: 2603, junk_after: 1'b0};
    vecs[2] = '{do_start: 1'b1, bitlen: 256,  exp_div: 127,  junk_after: 1'b0};

    nrst = 1'b0; rx = 1'b1; start = 1'b0; rx2 = 1'b1; start2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bauddiv", int'(bauddiv), DEFDIV);
    chk("rst_locked", int'(locked), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_state", int'(dbg_state), 0);
    nrst = 1'b1;
    idle(100);

    // Glitch: 8-cycle low pulse inside D0
    done_cnt = 0; err_cnt = 0;
    drive_bit(1'b0, 128);
    drive_bit(1'b1, 40);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 100);
    chk("glitch_err_cycles", err_cnt, 1);
    chk("glitch_done", done_cnt, 0);
    chk("glitch_locked", int'(locked), 0);
    chk("glitch_bauddiv", int'(bauddiv), DEFDIV);
    chk("glitch_busy", int'(busy), 1);
    prev_div = DEFDIV;

    // Calibration table
    foreach (vecs[k]) begin
      if (vecs[k].do_start) begin
        pulse_start();
        chk("recal_locked", int'(locked), 0);
        chk("recal_busy", int'(busy), 1);
        chk("recal_bauddiv_kept", int'(bauddiv), prev_div);
      end
      idle(100);
      done_cnt = 0; err_cnt = 0;
      send_byte(8'h55, vecs[k].bitlen);
      idle(20);
      exp_q.push_back(32'(vecs[k].exp_div));
      chk("cal_bauddiv", int'(bauddiv), int'(exp_q.pop_front()));
      chk("cal_locked", int'(locked), 1);
      chk("cal_busy", int'(busy), 0);
      chk("cal_done_pulses", done_cnt, 1);
      chk("cal_err", err_cnt, 0);
      chk("cal_state", int'(dbg_state), 3);
      prev_div = vecs[k].exp_div;
      if (vecs[k].junk_after) begin
        done_cnt = 0; err_cnt = 0;
        send_byte(8'hA3, vecs[k].bitlen);
        idle(20);
        chk("junk_bauddiv", int'(bauddiv), vecs[k].exp_div);
        chk("junk_locked", int'(locked), 1);
        chk("junk_done", done_cnt, 0);
        chk("junk_err", err_cnt, 0);
      end
    end

    // Reset in the middle of a measurement (after 3 falling edges)
    pulse_start();
    idle(100);
    drive_bit(1'b0, 128);
    drive_bit(1'b1, 128);
    drive_bit(1'b0, 128);
    drive_bit(1'b1, 128);
    drive_bit(1'b0, 64);
    chk("pre_rst_state", int'(dbg_state), 2);
    nrst = 1'b0;
    #1;
    chk("midrst_bauddiv", int'(bauddiv), DEFDIV);
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_err", int'(err), 0);
    chk("midrst_busy", int'(busy), 1);
    chk("midrst_state", int'(dbg_state), 0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    idle(100);
    done_cnt = 0; err_cnt = 0;
    send_byte(8'h55, 128);
    idle(20);
    chk("postrst_bauddiv", int'(bauddiv), 63);
    chk("postrst_locked", int'(locked), 1);
    chk("postrst_done", done_cnt, 1);

    // Timeout on the narrow instance: hold rx2 low after the start edge
    rx2 = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    rx2 = 1'b0;
    seen = 1'b0;
    lat = 0;
    for (int i = 1; i <= 6000; i++) begin
      @(posedge clk);
      #1;
      if (err2 && !seen) begin
        seen = 1'b1;
        lat = i;
        break;
      end
    end
    chk("to_err_seen", int'(seen), 1);
    chk("to_latency", lat, 4099);
    chk("to_state", int'(dbg_state2), 0);
    chk("to_locked", int'(locked2), 0);
    chk("to_busy", int'(busy2), 1);
    chk("to_bauddiv", int'(bauddiv2), DEFDIV2);
    @(posedge clk);
    #1;
    chk("to_err_one_cycle", int'(err2), 0);
    rx2 = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
